// File: rtl/dot_requant.sv
// ---------------------------------------------------------------------------
// dot_requant
//   Requantizes signed dot-product results from dot_engine into narrow signed
//   activations. Each accepted result has a bias added, is arithmetically
//   right-shifted with round-half-up, and is saturated to OUT_WIDTH bits.
//   Two-stage valid/ready pipeline with full backpressure, 1 result/cycle.
//
// Build option:
//   DOT_REQUANT_RELU_EN  when defined, negative results are forced to 0 after
//                        saturation (the ReLU clamp is not counted in sat_count).
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high; flushes both stages
//   in_valid   upstream result valid
//   in_ready   block accepts in_data this cycle
//   in_data    signed dot-product result
//   bias       signed bias, captured with in_data
//   shift      right-shift amount, captured with in_data
//   out_valid  out_data valid
//   out_ready  downstream accepts out_data
//   out_data   signed requantized value
//   sat_count  saturated outputs since reset (sticks at all-ones)
//   busy       either pipeline stage holds data
// ---------------------------------------------------------------------------
module dot_requant #(
    parameter int IN_WIDTH    = 18,
    parameter int BIAS_WIDTH  = 16,
    parameter int OUT_WIDTH   = 8,
    parameter int SHIFT_WIDTH = 5,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [IN_WIDTH-1:0]    in_data,
    input  logic signed [BIAS_WIDTH-1:0]  bias,
    input  logic        [SHIFT_WIDTH-1:0] shift,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [OUT_WIDTH-1:0]   out_data,
    output logic        [CNT_WIDTH-1:0]   sat_count,
    output logic                          busy
);

    // One extra bit holds in_data + bias without overflow; one more bit
    // leaves room for the rounding increment.
    localparam int SUM_W = IN_WIDTH + 1;
    localparam int RND_W = IN_WIDTH + 2;

    localparam logic signed [RND_W-1:0] RND_ONE = {{(RND_W-1){1'b0}}, 1'b1};
    localparam logic signed [RND_W-1:0] OUT_MAX =
        {{(RND_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [RND_W-1:0] OUT_MIN = ~OUT_MAX;

    // Pipeline state
    logic                          s1_valid_q,  s1_valid_d;
    logic signed [SUM_W-1:0]       s1_sum_q,    s1_sum_d;
    logic        [SHIFT_WIDTH-1:0] s1_shift_q,  s1_shift_d;
    logic                          s2_valid_q,  s2_valid_d;
    logic signed [OUT_WIDTH-1:0]   out_data_q,  out_data_d;
    logic        [CNT_WIDTH-1:0]   sat_count_q, sat_count_d;

    // Datapath intermediates
    logic                          s2_load;
    logic                          accept;
    logic        [SHIFT_WIDTH-1:0] sh;
    logic signed [RND_W-1:0]       sum_ext;
    logic signed [RND_W-1:0]       half;
    logic signed [RND_W-1:0]       rounded;
    logic signed [OUT_WIDTH-1:0]   result;
    logic                          sat_hit;

    // Handshake: S2 drains or refills whenever it is empty or being popped;
    // S1 can take new data whenever it is empty or emptying into S2.
    always_comb begin
        s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
        in_ready = ~s1_valid_q | s2_load;
        accept   = in_valid & in_ready;
    end

    // Stage 1: bias add with explicit sign extension of both operands.
    always_comb begin
        s1_sum_d = s1_sum_q;
        s1_shift_d = s1_shift_q;
        if (accept) begin
            s1_sum_d = {{(SUM_W-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data}
                     + {{(SUM_W-BIAS_WIDTH){bias[BIAS_WIDTH-1]}}, bias};
            s1_shift_d = shift;
        end

        if (accept) begin
            s1_valid_d = 1'b1;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage 2 datapath: round-half-up shift, then saturate.
    // Shift amounts beyond IN_WIDTH behave like IN_WIDTH, which already
    // reduces any sum to 0 or -1.
    always_comb begin
        if (32'(s1_shift_q) > IN_WIDTH) begin
            sh = SHIFT_WIDTH'(IN_WIDTH);
        end else begin
            sh = s1_shift_q;
        end

        sum_ext = {s1_sum_q[SUM_W-1], s1_sum_q};

        if (sh == '0) begin
            half = '0;
        end else begin
            half = RND_ONE <<< (sh - SHIFT_WIDTH'(1));
        end

        rounded = (sum_ext + half) >>> sh;

        sat_hit = 1'b0;
        result  = rounded[OUT_WIDTH-1:0];
        if (rounded > OUT_MAX) begin
            result  = OUT_MAX[OUT_WIDTH-1:0];
            sat_hit = 1'b1;
        end else if (rounded < OUT_MIN) begin
            result  = OUT_MIN[OUT_WIDTH-1:0];
            sat_hit = 1'b1;
        end

`ifdef DOT_REQUANT_RELU_EN
        // ReLU is applied after saturation and is not a saturation event.
        if (result[OUT_WIDTH-1]) begin
            result = '0;
        end
`endif
    end

    // Stage 2 registers and the sticky saturation counter.
    always_comb begin
        out_data_d  = out_data_q;
        sat_count_d = sat_count_q;
        if (s2_load) begin
            out_data_d = result;
            if (sat_hit && (sat_count_q != '1)) begin
                sat_count_d = sat_count_q + CNT_WIDTH'(1);
            end
        end

        if (s2_load) begin
            s2_valid_d = 1'b1;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            s1_shift_q  <= '0;
            s2_valid_q  <= 1'b0;
            out_data_q  <= '0;
            sat_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sum_q    <= s1_sum_d;
            s1_shift_q  <= s1_shift_d;
            s2_valid_q  <= s2_valid_d;
            out_data_q  <= out_data_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = out_data_q;
    assign sat_count = sat_count_q;
    assign busy      = s1_valid_q | s2_valid_q;

endmodule
